// File: rtl/sram_1p_64x128.sv
// Single-port synchronous SRAM model, 64 x 128, active-low CEN/WEN.
// Registered read port; reset clears only the output register.
module sram_1p_64x128 #(
    parameter int DW = 128,
    parameter int AW = 6
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          CEN,
    input  logic          WEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] q_d;
    logic [DW-1:0] q_q;
    logic          rd_en;
    logic          wr_en;

    always_comb begin
        rd_en = !CEN && WEN;
        wr_en = !CEN && !WEN;
        q_d   = q_q;
        if (rd_en) begin
            q_d = mem_q[A];
        end
    end

    // Array has no reset so writes still land while rst is asserted.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[A] <= D;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_sram_1p_64x128.sv
// Directed bench for sram_1p_64x128 with a word-array reference model
// compared against Q on every falling clock edge.
module tb_sram_1p_64x128;

    localparam logic [127:0] DEADBEEF = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [127:0] PAT_AA   = {16{8'hAA}};
    localparam logic [127:0] PAT_55   = {16{8'h55}};
    localparam logic [127:0] PAT_66   = 128'h66;

    logic         clk;
    logic         rst;
    logic         cen;
    logic         wen;
    logic [5:0]   a;
    logic [127:0] d;
    logic [127:0] q;

    int errors;
    int checks;

    // reference model
    logic [127:0] m_mem   [64];
    bit           m_valid [64];
    logic [127:0] m_q;
    bit           m_known;

    sram_1p_64x128 dut (
        .CLK (clk),
        .rst (rst),
        .CEN (cen),
        .WEN (wen),
        .A   (a),
        .D   (d),
        .Q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_q     = '0;
        m_known = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q     = '0;
            m_known = 1'b1;
        end
        if (clk && !cen) begin
            if (wen) begin
                if (!rst) begin
                    m_q     = m_mem[a];
                    m_known = m_valid[a];
                end
            end else begin
                m_mem[a]   = d;
                m_valid[a] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) chk("q_model", q, m_q);
    end

    task automatic do_write(input logic [5:0] addr, input logic [127:0] data);
        cen = 1'b0; wen = 1'b0; a = addr; d = data;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [5:0] addr);
        cen = 1'b0; wen = 1'b1; a = addr; d = '0;
        @(posedge clk); #1;
    endtask

    task automatic do_idle_toggle();
        cen = 1'b1;
        wen = 1'($urandom);
        a   = 6'($urandom);
        d   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cen = 1'b1; wen = 1'b1; a = '0; d = '0;
        rst = 1'b0;

        // 1: asynchronous reset pulse mid-cycle
        #3 rst = 1'b1;
        #1 chk("rst_async", q, 128'h0);
        @(posedge clk); #1;
        chk("rst_hold", q, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 2: write then read, Q untouched during the write
        do_write(6'd5, DEADBEEF);
        chk("no_write_through", q, 128'h0);
        do_read(6'd5);
        chk("read_a5", q, DEADBEEF);

        // 3: corner addresses, back-to-back reads
        do_write(6'd0, 128'h1);
        do_write(6'd63, 128'h3F);
        chk("q_held_over_writes", q, DEADBEEF);
        do_read(6'd0);
        chk("read_a0", q, 128'h1);
        do_read(6'd63);
        chk("read_a63", q, 128'h3F);

        // 4: idle cycles with toggling inputs
        do_read(6'd5);
        for (int i = 0; i < 4; i++) begin
            do_idle_toggle();
            chk("idle_hold", q, DEADBEEF);
        end
        do_read(6'd5);
        chk("reread_a5", q, DEADBEEF);

        // 5: overwrite, neighbour untouched
        do_write(6'd6, PAT_66);
        do_write(6'd7, PAT_AA);
        do_write(6'd7, PAT_55);
        do_read(6'd7);
        chk("overwrite_a7", q, PAT_55);
        do_read(6'd6);
        chk("neighbour_a6", q, PAT_66);

        // read immediately after write of new data
        do_write(6'd6, 128'h1234);
        do_read(6'd6);
        chk("raw_next_cycle", q, 128'h1234);

        // 6: fill, reset (with a write inside), read all
        for (int i = 0; i < 64; i++) do_write(6'(i), 128'(i));
        #3 rst = 1'b1;
        #1 chk("rst_async2", q, 128'h0);
        do_read(6'd20);
        chk("rst_blocks_read", q, 128'h0);
        do_write(6'd10, 128'd1000);
        chk("rst_hold2", q, 128'h0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            do_read(6'(i));
            if (i == 10) chk("write_in_rst", q, 128'd1000);
            else         chk("retained", q, 128'(i));
        end

        cen = 1'b1;
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
